// File: rtl/spi_acl_responder.sv
// spi_acl_responder: SPI responder that emulates the ADXL345 register interface of the Pmod ACL.
// It lets the PmodACL master be brought up and simulated without the sensor fitted.
//
// Ports:
//   CLK, RST             system clock, asynchronous active-high reset
//   SCLK, SS, SDI        SPI from master (mode 3, SS active low), asynchronous to CLK
//   SDO, SDO_OE          data to master and its tristate enable
//   x_in, y_in, z_in     axis samples, snapshotted at the start of each frame
//   reg_bw_rate          register 0x2C
//   reg_power_ctl        register 0x2D
//   reg_data_format      register 0x31
//   wr_stb, wr_addr,     one-CLK pulse with address/data for every completed write byte
//   wr_data
//
// SCLK half-period must be at least 4 CLK cycles.

module spi_acl_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCLK,
    input  logic        SS,
    input  logic        SDI,
    output logic        SDO,
    output logic        SDO_OE,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    output logic [7:0]  reg_bw_rate,
    output logic [7:0]  reg_power_ctl,
    output logic [7:0]  reg_data_format,
    output logic        wr_stb,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data
);

    typedef enum logic [1:0] {StIdle, StCmd, StRd, StWr} state_e;

    // Synchronisers: [0],[1] are the 2-flop synchroniser, [2] is the edge-detect stage.
    logic [2:0] sclk_sync_q;
    logic [2:0] ss_sync_q;
    logic [1:0] sdi_sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // SCLK idles high in mode 3. SS resets low so that a master still holding SS low
            // across reset release does not look like a new frame start.
            sclk_sync_q <= 3'b111;
            ss_sync_q   <= 3'b000;
            sdi_sync_q  <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
            ss_sync_q   <= {ss_sync_q[1:0], SS};
            sdi_sync_q  <= {sdi_sync_q[0], SDI};
        end
    end

    logic sclk_rise, sclk_fall, ss_fall, ss_high, sdi_s;
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_high   = ss_sync_q[1];
    assign sdi_s     = sdi_sync_q[1];

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [5:0]  addr_q, addr_d;
    logic        mb_q, mb_d;
    logic [47:0] snap_q, snap_d;
    logic        sdo_q, sdo_d;
    logic        sdo_oe_q, sdo_oe_d;
    logic [7:0]  bw_rate_q, bw_rate_d;
    logic [7:0]  power_ctl_q, power_ctl_d;
    logic [7:0]  data_format_q, data_format_d;
    logic        wr_stb_q, wr_stb_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    // Byte completed by the current SCLK rising edge.
    logic [7:0] shift_in;
    assign shift_in = {shift_q[6:0], sdi_s};

    // Address of the next byte to transfer: the command address while in CMD, otherwise
    // the current address, advanced (with 6-bit wrap) in multi-byte mode.
    logic [5:0] load_addr;
    always_comb begin
        load_addr = addr_q;
        if (state_q == StCmd) begin
            load_addr = shift_in[5:0];
        end else if (mb_q) begin
            load_addr = addr_q + 6'd1;
        end
    end

    logic [7:0] rd_byte;
    always_comb begin
        rd_byte = 8'h00;
        case (load_addr)
            6'h00:   rd_byte = DEVID;
            6'h2C:   rd_byte = bw_rate_q;
            6'h2D:   rd_byte = power_ctl_q;
            6'h31:   rd_byte = data_format_q;
            6'h32:   rd_byte = snap_q[7:0];
            6'h33:   rd_byte = snap_q[15:8];
            6'h34:   rd_byte = snap_q[23:16];
            6'h35:   rd_byte = snap_q[31:24];
            6'h36:   rd_byte = snap_q[39:32];
            6'h37:   rd_byte = snap_q[47:40];
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        addr_d        = addr_q;
        mb_d          = mb_q;
        snap_d        = snap_q;
        sdo_d         = sdo_q;
        bw_rate_d     = bw_rate_q;
        power_ctl_d   = power_ctl_q;
        data_format_d = data_format_q;
        wr_stb_d      = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;

        // SS deasserted overrides everything, including a byte completing in the same cycle.
        if (ss_high) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = 3'd0;
                        snap_d    = {z_in, y_in, x_in};
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            mb_d   = shift_in[6];
                            addr_d = load_addr;
                            if (shift_in[7]) begin
                                state_d = StRd;
                                tx_d    = rd_byte;
                            end else begin
                                state_d = StWr;
                            end
                        end
                    end
                end
                StRd: begin
                    if (sclk_fall) begin
                        sdo_d = tx_q[7];
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = load_addr;
                            tx_d   = rd_byte;
                        end
                    end
                end
                StWr: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_stb_d  = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = shift_in;
                            case (addr_q)
                                6'h2C:   bw_rate_d     = shift_in;
                                6'h2D:   power_ctl_d   = shift_in;
                                6'h31:   data_format_d = shift_in;
                                default: ;
                            endcase
                            addr_d = load_addr;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        sdo_oe_d = (state_d == StRd);
        if (state_d != StRd) begin
            sdo_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            tx_q          <= 8'h00;
            addr_q        <= 6'd0;
            mb_q          <= 1'b0;
            snap_q        <= 48'd0;
            sdo_q         <= 1'b0;
            sdo_oe_q      <= 1'b0;
            bw_rate_q     <= BW_RATE_RST;
            power_ctl_q   <= 8'h00;
            data_format_q <= 8'h00;
            wr_stb_q      <= 1'b0;
            wr_addr_q     <= 6'd0;
            wr_data_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            addr_q        <= addr_d;
            mb_q          <= mb_d;
            snap_q        <= snap_d;
            sdo_q         <= sdo_d;
            sdo_oe_q      <= sdo_oe_d;
            bw_rate_q     <= bw_rate_d;
            power_ctl_q   <= power_ctl_d;
            data_format_q <= data_format_d;
            wr_stb_q      <= wr_stb_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign SDO             = sdo_q;
    assign SDO_OE          = sdo_oe_q;
    assign reg_bw_rate     = bw_rate_q;
    assign reg_power_ctl   = power_ctl_q;
    assign reg_data_format = data_format_q;
    assign wr_stb          = wr_stb_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;

endmodule
